seq_divider: RTL

Multi-cycle restoring integer divider for the execution stage, the subtractive counterpart of the combinational add/subtract datapath. It accepts one signed or unsigned division per request and computes one quotient bit per cycle. It returns quotient and remainder with a one-cycle done pulse. Division by zero and signed overflow follow RISC-V M-extension semantics, so the ALU can forward DIV/DIVU/REM/REMU results directly.

---
 rtl/seq_divider.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider with RISC-V DIV/REM corner-case results
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] dvd_orig;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             neg_quo;
    logic             neg_rem;
    logic             div_zero;
    logic             ovf;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH:0]   trial;

    assign ready   = (state == IDLE);
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    // The quotient register doubles as the dividend shift register: its MSB feeds each trial.
    assign trial   = {1'b0, rem[WIDTH-2:0], quo[WIDTH-1]} - {1'b0, dvs_mag};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dvd_orig  <= '0;
            dvs_mag   <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_orig <= dividend;
                        quo      <= dvd_neg ? -dividend : dividend;
                        dvs_mag  <= dvs_neg ? -divisor : divisor;
                        neg_quo  <= dvd_neg ^ dvs_neg;
                        neg_rem  <= dvd_neg;
                        div_zero <= (divisor == '0);
                        ovf      <= is_signed && (dividend == MOST_NEG) && (divisor == '1);
                        rem      <= '0;
                        cnt      <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                    end
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_zero) begin
                        quotient  <= '1;
                        remainder <= dvd_orig;
                    end else if (ovf) begin
                        quotient  <= dvd_orig;
                        remainder <= '0;
                    end else begin
                        quotient  <= neg_quo ? -quo : quo;
                        remainder <= neg_rem ? -rem : rem;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
